// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Divide support is built only when MULDIV_DIV_EN is defined; otherwise DIV/DIVU starts are ignored.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_rs,
  input  logic [WIDTH-1:0] data_rt,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] data_w,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] LastIter = 6'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e               state_q, state_d;
  logic                 neg_a_q, neg_a_d;
  logic                 neg_b_q, neg_b_d;
  logic [WIDTH-1:0]     mag_a_q, mag_a_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 op_ok;
  logic                 in_neg_a, in_neg_b;
  logic [WIDTH-1:0]     in_mag_a, in_mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH-1:0]   prod_fix;

  // Sign flags are only ever set for signed ops, so fixups need no op check.
  assign in_neg_a = ~op[0] & data_rs[WIDTH-1];
  assign in_neg_b = ~op[0] & data_rt[WIDTH-1];
  assign in_mag_a = in_neg_a ? -data_rs : data_rs;
  assign in_mag_b = in_neg_b ? -data_rt : data_rt;

  // Multiplier sits in acc low half and shifts out as the product shifts in.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
  logic                 is_div_q, is_div_d;
  logic [WIDTH-1:0]     mag_b_q, mag_b_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [WIDTH-1:0]     quot_fix, rem_fix, rs_raw;

  assign op_ok     = 1'b1;
  // WIDTH+1-bit partial remainder; the difference always fits in WIDTH bits when taken.
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, mag_b_q};
  assign div_diff  = div_shift[WIDTH-1:0] - mag_b_q;
  assign quot_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = neg_a_q ? -rem_q : rem_q;
  assign rs_raw    = neg_a_q ? -mag_a_q : mag_a_q;
`else
  assign op_ok     = ~op[1];
`endif

  always_comb begin
    state_d = state_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    mag_a_d = mag_a_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
    is_div_d = is_div_q;
    mag_b_d  = mag_b_q;
    rem_d    = rem_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start && op_ok) begin
          neg_a_d = in_neg_a;
          neg_b_d = in_neg_b;
          mag_a_d = in_mag_a;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
`ifdef MULDIV_DIV_EN
          is_div_d = op[1];
          mag_b_d  = in_mag_b;
          rem_d    = '0;
          acc_d    = {{WIDTH{1'b0}}, op[1] ? in_mag_a : in_mag_b};
`else
          acc_d    = {{WIDTH{1'b0}}, in_mag_b};
`endif
        end else if (!start) begin
          if (hi_wr) hi_d = data_w;
          if (lo_wr) lo_d = data_w;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 6'd1;
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          acc_d = {{WIDTH{1'b0}}, acc_q[WIDTH-2:0], div_ge};
          rem_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
        end else begin
          acc_d = mul_next;
        end
`else
        acc_d = mul_next;
`endif
        if (cnt_q == LastIter) state_d = StFin;
      end
      StFin: begin
`ifdef MULDIV_DIV_EN
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (mag_b_q == '0) begin
          // Divide by zero is forced, not taken from the iteration.
          hi_d = rs_raw;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
`else
        {hi_d, lo_d} = prod_fix;
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      mag_a_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q <= 1'b0;
      mag_b_q  <= '0;
      rem_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      mag_a_q <= mag_a_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MULDIV_DIV_EN
      is_div_q <= is_div_d;
      mag_b_q  <= mag_b_d;
      rem_q    <= rem_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, hazards, reset abort and random ops
// against an arithmetic reference model. Divide cases follow MULDIV_DIV_EN.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, hi_wr, lo_wr;
  logic [1:0]  op;
  logic [31:0] data_rs, data_rt, data_w;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .data_rs (data_rs),
    .data_rt (data_rt),
    .hi_wr   (hi_wr),
    .lo_wr   (lo_wr),
    .data_w  (data_w),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  // Reference result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      p;
    int          sa, sb, q, r;
    logic [63:0] res;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'b00: begin
        p   = longint'(sa) * longint'(sb);
        res = p;
      end
      2'b01: res = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r, q};
        end
      end
      default: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Drives one op from a negedge; returns done latency (-1 if none) and busy/hold violations.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic mt_with_start, input int hz_cycle, output int lat,
                        output int viol, output logic [31:0] rhi, output logic [31:0] rlo);
    logic [31:0] old_hi, old_lo;
    old_hi  = hi;
    old_lo  = lo;
    start   = 1'b1;
    op      = o;
    data_rs = a;
    data_rt = b;
    hi_wr   = mt_with_start;
    data_w  = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    hi_wr = 1'b0;
    lat   = -1;
    viol  = 0;
    rhi   = hi;
    rlo   = lo;
    for (int k = 0; k <= 40 && lat < 0; k++) begin
      if (done) begin
        lat = k;
        rhi = hi;
        rlo = lo;
        if (busy) viol++;
      end else if (!busy || hi !== old_hi || lo !== old_lo) begin
        viol++;
      end
      if (lat < 0) begin
        if (k == hz_cycle) begin
          hi_wr   = 1'b1;
          lo_wr   = 1'b1;
          data_w  = 32'hFFFF_0000;
          start   = 1'b1;
          op      = 2'b01;
          data_rs = 32'h55;
          data_rt = 32'h3;
        end
        @(negedge clk);
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        start = 1'b0;
      end
    end
  endtask

  task automatic run_ignored(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             output int viol);
    logic [31:0] old_hi, old_lo;
    old_hi  = hi;
    old_lo  = lo;
    start   = 1'b1;
    op      = o;
    data_rs = a;
    data_rt = b;
    @(negedge clk);
    start = 1'b0;
    viol  = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy || done || hi !== old_hi || lo !== old_lo) viol++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'b00; data_rs = '0; data_rt = '0;
    hi_wr = 1'b0; lo_wr = 1'b0; data_w = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
  endtask

  task automatic test_mt();
    lo_wr = 1'b1; data_w = 32'h1234;
    @(negedge clk);
    lo_wr = 1'b0;
    n_checks++; if (lo !== 32'h1234) begin n_fail++; $display("FAIL mtlo_lo: got %h want 00001234", lo); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL mtlo_hi: got %h want 0", hi); end
    hi_wr = 1'b1; lo_wr = 1'b1; data_w = 32'h0BAD_F00D;
    @(negedge clk);
    hi_wr = 1'b0; lo_wr = 1'b0;
    n_checks++; if (hi !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL mtboth_hi: got %h want 0badf00d", hi); end
    n_checks++; if (lo !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL mtboth_lo: got %h want 0badf00d", lo); end
  endtask

  task automatic test_mult();
    int lat, viol;
    logic [31:0] rhi, rlo;
    run_op(2'b01, 32'd7, 32'd6, 1'b0, -1, lat, viol, rhi, rlo);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL multu_latency: got %0d want 33", lat); end
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL multu_busy_hold: got %0d bad cycles want 0", viol); end
    n_checks++; if ({rhi, rlo} !== 64'h2A) begin n_fail++; $display("FAIL multu_7x6: got %h_%h want 00000000_0000002a", rhi, rlo); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b want 0", done); end
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, -1, lat, viol, rhi, rlo);
    n_checks++; if ({rhi, rlo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_fail++; $display("FAIL mult_neg3x5: got %h_%h want ffffffff_fffffff1", rhi, rlo); end
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, lat, viol, rhi, rlo);
    n_checks++; if ({rhi, rlo} !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL multu_max: got %h_%h want fffffffe_00000001", rhi, rlo); end
  endtask

  task automatic test_div();
    int lat, viol;
    logic [31:0] rhi, rlo;
`ifdef MULDIV_DIV_EN
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, -1, lat, viol, rhi, rlo);
    n_checks++; if (lat !== 33 || viol !== 0) begin n_fail++; $display("FAIL div_timing: got lat %0d viol %0d want 33/0", lat, viol); end
    n_checks++; if ({rhi, rlo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL div_neg7by2: got %h_%h want ffffffff_fffffffd", rhi, rlo); end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, lat, viol, rhi, rlo);
    n_checks++; if ({rhi, rlo} !== 64'h0000_0000_8000_0000) begin n_fail++; $display("FAIL div_overflow: got %h_%h want 00000000_80000000", rhi, rlo); end
    run_op(2'b11, 32'h64, 32'h0, 1'b0, -1, lat, viol, rhi, rlo);
    n_checks++; if ({rhi, rlo} !== 64'h0000_0064_FFFF_FFFF) begin n_fail++; $display("FAIL divu_by_zero: got %h_%h want 00000064_ffffffff", rhi, rlo); end
`else
    run_ignored(2'b11, 32'h64, 32'h0, viol);
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL divu_disabled_ignored: got %0d bad cycles want 0", viol); end
    run_ignored(2'b10, 32'hFFFF_FFF9, 32'd2, viol);
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL div_disabled_ignored: got %0d bad cycles want 0", viol); end
`endif
  endtask

  task automatic test_hazards();
    int lat, viol;
    logic [31:0] rhi, rlo;
    logic [63:0] exp;
    run_op(2'b01, 32'h1111_0000, 32'h10, 1'b1, -1, lat, viol, rhi, rlo);
    exp = model(2'b01, 32'h1111_0000, 32'h10);
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL start_mthi_hold: got %0d bad cycles want 0", viol); end
    n_checks++; if ({rhi, rlo} !== exp) begin n_fail++; $display("FAIL start_mthi_result: got %h_%h want %h", rhi, rlo, exp); end
    run_op(2'b00, 32'hFFFF_8000, 32'h123, 1'b0, 5, lat, viol, rhi, rlo);
    exp = model(2'b00, 32'hFFFF_8000, 32'h123);
    n_checks++; if (lat !== 33 || viol !== 0) begin n_fail++; $display("FAIL run_hazard_timing: got lat %0d viol %0d want 33/0", lat, viol); end
    n_checks++; if ({rhi, rlo} !== exp) begin n_fail++; $display("FAIL run_hazard_result: got %h_%h want %h", rhi, rlo, exp); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL run_hazard_no_second: got busy %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat, viol;
    logic [31:0] rhi, rlo, a, b;
    logic [1:0] o;
    for (int i = 0; i < 3; i++) begin
      o = 2'(i % 2);
      a = $urandom;
      b = $urandom;
      run_op(o, a, b, 1'b0, -1, lat, viol, rhi, rlo);
      n_checks++; if (lat !== 33 || viol !== 0) begin n_fail++; $display("FAIL b2b_timing[%0d]: got lat %0d viol %0d want 33/0", i, lat, viol); end
      n_checks++; if ({rhi, rlo} !== model(o, a, b)) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h_%h want %h", i, rhi, rlo, model(o, a, b)); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, viol;
    logic [31:0] rhi, rlo, a, b;
    hi_wr = 1'b1; lo_wr = 1'b1; data_w = 32'hA5A5_5A5A;
    @(negedge clk);
    hi_wr = 1'b0; lo_wr = 1'b0;
    start = 1'b1; op = 2'b01; data_rs = $urandom; data_rt = $urandom;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
    n_checks++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL midreset_hilo: got %h_%h want 0", hi, lo); end
    viol = 0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) viol++;
      @(negedge clk);
    end
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d bad cycles want 0", viol); end
    a = $urandom;
    b = $urandom;
    run_op(2'b01, a, b, 1'b0, -1, lat, viol, rhi, rlo);
    n_checks++; if (lat !== 33 || {rhi, rlo} !== model(2'b01, a, b)) begin
      n_fail++; $display("FAIL midreset_recover: got lat %0d %h_%h want 33 %h", lat, rhi, rlo, model(2'b01, a, b));
    end
  endtask

  task automatic test_random();
    int lat, viol;
    logic [31:0] rhi, rlo, a, b;
    logic [1:0] o;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
`ifndef MULDIV_DIV_EN
      if (o[1]) begin
        run_ignored(o, a, b, viol);
        n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL rand_ignored[%0d]: got %0d bad cycles want 0", i, viol); end
        continue;
      end
`endif
      run_op(o, a, b, 1'b0, -1, lat, viol, rhi, rlo);
      n_checks++; if (lat !== 33 || viol !== 0) begin n_fail++; $display("FAIL rand_timing[%0d]: got lat %0d viol %0d want 33/0", i, lat, viol); end
      n_checks++; if ({rhi, rlo} !== model(o, a, b)) begin
        n_fail++; $display("FAIL rand_result[%0d] op %0d %h %h: got %h_%h want %h", i, o, a, b, rhi, rlo, model(o, a, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_mt();
    test_mult();
    test_div();
    test_hazards();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
